// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, the SubBytes FSM encoding and a column accessor.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NB      = 4;
    localparam int AES_COL_W   = AES_STATE_W / AES_NB;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sbox_state_e;

    // Column c of a column-major state; column 0 sits in the top 32 bits.
    function automatic logic [AES_COL_W-1:0] col_get(input logic [AES_STATE_W-1:0] s,
                                                     input logic [1:0]             c);
        return s[AES_STATE_W-1-AES_COL_W*int'(c) -: AES_COL_W];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box (FIPS-197), one byte in, one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] in_i,
    output logic [AES_BYTE_W-1:0] out_o
);

    // Entry 0 occupies the top byte, so entry x starts at bit 2047-8x.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TABLE[~{in_i, 3'b000} -: AES_BYTE_W];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: substitutes COLS_PER_CYCLE columns per cycle in place, then
// holds the finished state for the downstream ShiftRows stage.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] substituted_state_array
);

    localparam int         SLICE_W  = AES_COL_W * COLS_PER_CYCLE;
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] COL_SPAN = 2'(COLS_PER_CYCLE - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("sub_bytes_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    sbox_state_e            state_q;
    logic [1:0]             col_q;
    logic [AES_STATE_W-1:0] work_q;
    logic [AES_STATE_W-1:0] work_d;
    logic                   out_valid_q;
    logic                   in_ready_q;
    logic [SLICE_W-1:0]     cur_flat;
    logic [SLICE_W-1:0]     sub_flat;
    logic                   col_last;

    // Columns col_q .. col_q+COLS_PER_CYCLE-1 feed the shared S-box bank.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign cur_flat[SLICE_W-1-AES_COL_W*g -: AES_COL_W] = col_get(work_q, col_q + 2'(g));
        for (genvar b = 0; b < AES_NB; b++) begin : g_byte
            aes_sbox u_sbox (
                .in_i  (cur_flat[SLICE_W-1-AES_COL_W*g-AES_BYTE_W*b -: AES_BYTE_W]),
                .out_o (sub_flat[SLICE_W-1-AES_COL_W*g-AES_BYTE_W*b -: AES_BYTE_W])
            );
        end
    end

    always_comb begin
        work_d = work_q;
        for (int j = 0; j < AES_NB; j++) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                if (col_q + 2'(g) == 2'(j)) begin
                    work_d[AES_STATE_W-1-AES_COL_W*j -: AES_COL_W] =
                        sub_flat[SLICE_W-1-AES_COL_W*g -: AES_COL_W];
                end
            end
        end
    end

    assign col_last = (col_q + COL_SPAN) == 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q     <= in_state;
                        col_q      <= 2'd0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    col_q  <= col_q + COL_STEP;
                    if (col_last) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // The data register keeps the result after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    col_q       <= 2'd0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready                = in_ready_q;
    assign out_valid               = out_valid_q;
    assign substituted_state_array = work_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter at COLS_PER_CYCLE = 1, 2 and 4.
module tb_sub_bytes_iter;

    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] ALL_00   = 128'h00000000000000000000000000000000;
    localparam logic [127:0] ALL_63   = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ALL_FF   = 128'hffffffffffffffffffffffffffffffff;
    localparam logic [127:0] ALL_16   = 128'h16161616161616161616161616161616;
    localparam logic [127:0] B0153_IN = 128'h01530000000000000000000000000000;
    localparam logic [127:0] B0153_EX = 128'h7ced6363636363636363636363636363;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   iv = 3'b000;
    logic [2:0]   ordy = 3'b000;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [127:0] is_v [3];
    logic [127:0] os_v [3];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [129:0] sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse in GF(2^8) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
               {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_m(s[127-8*i -: 8]);
        return r;
    endfunction

    for (genvar k = 0; k < 3; k++) begin : g_dut
        logic [129:0] ent;
        sub_bytes_iter #(.COLS_PER_CYCLE(1 << k)) u_dut (
            .clk                     (clk),
            .rst                     (rst),
            .in_valid                (iv[k]),
            .in_ready                (ir[k]),
            .in_state                (is_v[k]),
            .out_valid               (ov[k]),
            .out_ready               (ordy[k]),
            .substituted_state_array (os_v[k])
        );
        always @(negedge clk) begin
            if (!rst && ov[k] && ordy[k]) begin
                chk_eq("sb_pending", 128'(sb_q.size() != 0), 128'd1);
                if (sb_q.size() != 0) begin
                    ent = sb_q.pop_front();
                    chk_eq("sb_inst", 128'(ent[129:128]), 128'(k));
                    chk_eq("sb_data", os_v[k], ent[127:0]);
                end
            end
        end
    end

    task automatic send(input int k, input logic [127:0] d, input bit push,
                        input logic [127:0] exp, output int acc);
        int n = 0;
        @(negedge clk);
        is_v[k] = d;
        iv[k]   = 1'b1;
        if (push) sb_q.push_back({2'(k), exp});
        while (!ir[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_eq("accept_wait", 128'(n < 50), 128'd1);
        @(posedge clk);
        #1;
        acc   = cyc;
        iv[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input int acc, input int lat);
        int n = 0;
        while (!ov[k] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq("latency", 128'(cyc - acc), 128'(lat));
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("drain", 128'(sb_q.size()), 128'd0);
    endtask

    task automatic run_one(input int k, input logic [127:0] d, input logic [127:0] exp);
        int acc;
        send(k, d, 1'b1, exp, acc);
        wait_out(k, acc, 4 >> k);
        drain();
    endtask

    initial begin
        int acc, t0, t1, n;
        logic [127:0] rv, rv2;
        for (int k = 0; k < 3; k++) is_v[k] = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_eq("rst_out_valid", 128'(ov[k]), 128'd0);
            chk_eq("rst_out_data", os_v[k], 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk_eq("rst_in_ready", 128'(ir[k]), 128'd1);
        @(posedge clk);
        #1 ordy = 3'b111;

        run_one(0, APPB_IN, APPB_OUT);
        run_one(0, ALL_00, ALL_63);
        run_one(0, ALL_FF, ALL_16);
        run_one(0, B0153_IN, B0153_EX);

        // Backpressure: hold the result, refuse a second block meanwhile.
        ordy[0] = 1'b0;
        send(0, APPB_IN, 1'b1, APPB_OUT, acc);
        wait_out(0, acc, 4);
        @(negedge clk);
        is_v[0] = ALL_FF;
        iv[0]   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk_eq("bp_out_valid", 128'(ov[0]), 128'd1);
            chk_eq("bp_out_data", os_v[0], APPB_OUT);
            chk_eq("bp_in_ready", 128'(ir[0]), 128'd0);
        end
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("bp_release_valid", 128'(ov[0]), 128'd0);
        chk_eq("bp_release_ready", 128'(ir[0]), 128'd1);
        repeat (2) @(posedge clk);
        #1;
        chk_eq("bp_no_accept", 128'(ir[0]), 128'd1);
        chk_eq("drain_bp", 128'(sb_q.size()), 128'd0);

        // Back-to-back with in_valid and out_ready held high.
        rv = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        is_v[0] = APPB_IN;
        iv[0]   = 1'b1;
        sb_q.push_back({2'd0, APPB_OUT});
        n = 0;
        while (!ir[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        t0      = cyc;
        is_v[0] = rv;
        sb_q.push_back({2'd0, model_state(rv)});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ir[0] && n < 50);
        @(posedge clk);
        #1;
        t1    = cyc;
        iv[0] = 1'b0;
        chk_eq("b2b_spacing", 128'(t1 - t0), 128'd6);
        drain();

        // Asynchronous reset two cycles into BUSY discards the block.
        send(0, ALL_FF, 1'b0, ALL_16, acc);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk_eq("mid_rst_valid", 128'(ov[0]), 128'd0);
        chk_eq("mid_rst_data", os_v[0], 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("mid_rst_ready", 128'(ir[0]), 128'd1);
        chk_eq("mid_rst_idle", 128'(ov[0]), 128'd0);
        run_one(0, ALL_00, ALL_63);

        for (int i = 0; i < 3; i++) begin
            rv2 = {$urandom, $urandom, $urandom, $urandom};
            run_one(0, rv2, model_state(rv2));
        end

        for (int k = 1; k < 3; k++) begin
            run_one(k, APPB_IN, APPB_OUT);
            run_one(k, B0153_IN, B0153_EX);
            rv2 = {$urandom, $urandom, $urandom, $urandom};
            run_one(k, rv2, model_state(rv2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
